mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory load/store interface.
- Accepts one load/store request at a time from the MEM pipeline stage and drives the memory port (strobes, word-aligned address, write data).
- Little-endian: the byte at address A occupies bits [7:0].
- Performs byte/halfword/word loads with sign or zero extension, and sub-word stores by read-modify-write. Returns the result or an error to the pipeline.

Parameters:
TIMEOUT, 16, max cycles spent in one memory state waiting for mem_ack_i before aborting with error (>=2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
req_valid_i  input  1  pipeline request valid
req_ready_o  output  1  unit can accept a request (high only in IDLE)
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-justified
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  32  extended load data (0 for stores/errors)
resp_err_o  output  1  misaligned/illegal size/timeout, valid with resp_valid_o
mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
mem_data_o  output  32  write data to memory
mem_read_o  output  1  read strobe
mem_write_o  output  1  write strobe
mem_data_i  input  32  read data from memory
mem_ack_i  input  1  memory completed current access this cycle

Behaviour:
- Reset (async, immediate): state IDLE, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, timeout counter=0.
- Reset mid-access: strobes drop immediately. No response is produced for the aborted request.
- States: IDLE, RD, RMW_RD, WR, RESP. All outputs are registered.
- IDLE:
  - req_ready_o=1. A request is accepted on a clock edge with req_valid_i=1. Addr, size, we, unsigned and wdata are latched.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11 -> RESP with err=1. No strobe is issued.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD / RMW_RD: mem_read_o=1. On mem_ack_i, mem_data_i is captured on that edge.
  - RD -> RESP. resp_rdata_o = lane selected by addr[1:0] (byte) or addr[1] (half), then extended.
  - RMW_RD -> WR. The merge word is the captured data with the target byte/half lanes replaced by wdata[7:0] or wdata[15:0].
- WR: mem_write_o=1, mem_data_o = merge word (word store: wdata). On mem_ack_i -> RESP with err=0, rdata=0.
- mem_read_o and mem_write_o are never high in the same cycle. Both are low in IDLE and RESP.
- mem_addr_o is held stable for the whole access, including across RMW_RD->WR.
- Timeout:
  - The counter clears on every state entry and increments each cycle in RD/RMW_RD/WR without ack.
  - When it reaches TIMEOUT-1 with no ack: strobes drop next cycle, -> RESP with err=1, rdata=0.
  - A timeout during RMW_RD means no write is issued.
- RESP: resp_valid_o=1 for exactly one cycle, req_ready_o=0, then -> IDLE. resp_rdata_o/resp_err_o hold their values until the next RESP.
- mem_ack_i is ignored in IDLE and RESP.
- Latency:
  - Load or word store with ack in the first memory cycle: accept edge t, strobe cycle t+1, resp_valid_o cycle t+2.
  - Sub-word store: resp_valid_o at t+3.
- Back-to-back: a new request is accepted in the first IDLE cycle after RESP, so minimum request spacing is 3 cycles.

Test Plan:
- Byte load: memory word 0x80FF_7F01 at 0x10; lb addr 0x13 -> resp_rdata_o=0xFFFF_FF80 two cycles after accept. lbu 0x12 -> 0x0000_00FF. lb 0x11 -> 0x0000_007F.
- Half load: lh 0x12 on the same word -> 0xFFFF_80FF. lhu 0x10 -> 0x0000_7F01. lh 0x11 -> resp_err_o=1, no mem_read_o pulse.
- Sub-word store: memory 0x1122_3344 at 0x20; sb 0x21 data 0xAB -> read then write with mem_data_o=0x1122_AB44. sh 0x22 data 0xBEEF -> 0xBEEF_3344. resp_valid_o at t+3.
- Word store then load: sw 0x0000_0004 data 0xDEAD_BEEF, then lw 0x04 -> 0xDEAD_BEEF. Ack delayed 3 cycles -> response delayed exactly 3 cycles, address stable throughout.
- Timeout: ack never asserted on lw 0x08 -> strobe high TIMEOUT cycles, then resp_err_o=1, rdata=0. RMW timeout -> mem_write_o never asserted.
- Async reset asserted mid-WR -> mem_write_o=0 before the next edge. No resp_valid_o. req_ready_o=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the data-memory load/store port. Takes one request at a
//   time from the MEM stage, issues word-aligned read/write strobes, and returns
//   extended load data or an error. Byte/half stores use read-modify-write.
//   Little-endian: byte at address A sits in bits [7:0] of its word lane.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   req_valid_i / req_ready_o          request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//                                      request fields, latched on accept
//   resp_valid_o, resp_rdata_o, resp_err_o
//                                      one-cycle response; data/err hold until next response
//   mem_addr_o, mem_data_o, mem_read_o, mem_write_o
//                                      memory command side
//   mem_data_i, mem_ack_i              memory read data and completion
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request
// S_RD     | load read in flight
// S_RMW_RD | read half of a byte/half store
// S_WR     | write in flight (word store or merged RMW word)
// S_RESP   | one-cycle response to the pipeline
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [1:0]     a_q;
   logic [1:0]     size_q;
   logic           uns_q;
   logic [15:0]    wdata_q;
   logic           misaligned;

   assign misaligned = (req_size_i == 2'b11) ||
                       (req_size_i == 2'b01 && req_addr_i[0]) ||
                       (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                         input logic [1:0] sz, input logic [15:0] d);
      logic [31:0] r;
      r = w;
      if (sz == 2'b00)
         r[{a, 3'b000} +: 8] = d[7:0];
      else if (a[1])
         r[31:16] = d;
      else
         r[15:0] = d;
      return r;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         cnt          <= '0;
         a_q          <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         mem_read_o   <= 1'b0;
         mem_write_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (req_valid_i) begin
                  a_q         <= req_addr_i[1:0];
                  size_q      <= req_size_i;
                  uns_q       <= req_unsigned_i;
                  wdata_q     <= req_wdata_i[15:0];
                  req_ready_o <= 1'b0;
                  mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                  if (misaligned) begin
                     state        <= S_RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                  end else if (!req_we_i) begin
                     state      <= S_RD;
                     mem_read_o <= 1'b1;
                  end else if (req_size_i == 2'b10) begin
                     state       <= S_WR;
                     mem_write_o <= 1'b1;
                     mem_data_o  <= req_wdata_i;
                  end else begin
                     state      <= S_RMW_RD;
                     mem_read_o <= 1'b1;
                  end
               end
            end

            S_RD, S_RMW_RD, S_WR: begin
               if (mem_ack_i) begin
                  cnt        <= '0;
                  mem_read_o <= 1'b0;
                  if (state == S_RMW_RD) begin
                     // address stays put; only the strobe flips to write
                     state       <= S_WR;
                     mem_write_o <= 1'b1;
                     mem_data_o  <= merge(mem_data_i, a_q, size_q, wdata_q);
                  end else begin
                     state        <= S_RESP;
                     mem_write_o  <= 1'b0;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b0;
                     resp_rdata_o <= (state == S_RD) ? load_ext(mem_data_i, a_q, size_q, uns_q)
                                                     : 32'h0;
                  end
               end else if (cnt == CNT_LAST) begin
                  // abort: no write follows a timed-out RMW read
                  cnt          <= '0;
                  state        <= S_RESP;
                  mem_read_o   <= 1'b0;
                  mem_write_o  <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b1;
                  resp_rdata_o <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RESP: begin
               cnt          <= '0;
               state        <= S_IDLE;
               resp_valid_o <= 1'b0;
               req_ready_o  <= 1'b1;
            end

            default: begin
               state       <= S_IDLE;
               req_ready_o <= 1'b1;
               mem_read_o  <= 1'b0;
               mem_write_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_read_o, mem_write_o, mem_ack_i;

   int compared = 0;
   int mismatched = 0;

   // observations from the last request
   int          lat, n_rd, n_wr, phase_cnt;
   logic        got_resp, both_hi, addr_ok, r_err;
   logic [31:0] r_data, wdata_seen;

   mem_access_unit #(.TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while idle. ack_dly < 0 means never acknowledge;
   // otherwise ack in the (ack_dly+1)-th cycle of each strobe phase.
   task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_dly, input logic [31:0] rd_word);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
      req_addr_i = addr; req_wdata_i = wd;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      lat = 0; n_rd = 0; n_wr = 0; phase_cnt = 0;
      got_resp = 1'b0; both_hi = 1'b0; addr_ok = 1'b1; r_err = 1'b0;
      r_data = 32'h0; wdata_seen = 32'h0;
      for (int c = 1; c <= 60 && !got_resp; c++) begin
         if (mem_read_o) n_rd++;
         if (mem_write_o) begin n_wr++; wdata_seen = mem_data_o; end
         if (mem_read_o && mem_write_o) both_hi = 1'b1;
         if ((mem_read_o || mem_write_o) && mem_addr_o !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
         if (resp_valid_o) begin
            got_resp = 1'b1; lat = c; r_data = resp_rdata_o; r_err = resp_err_o;
         end
         mem_data_i = rd_word;
         if (mem_read_o || mem_write_o) begin
            if (ack_dly >= 0 && phase_cnt == ack_dly) begin
               mem_ack_i = 1'b1; phase_cnt = 0;
            end else begin
               mem_ack_i = 1'b0; phase_cnt++;
            end
         end else begin
            mem_ack_i = 1'b0; phase_cnt = 0;
         end
         @(negedge clk_i);
      end
      mem_ack_i = 1'b0;
      check("resp_seen", {31'b0, got_resp}, 32'd1);
      check("resp_one_cycle", {31'b0, resp_valid_o}, 32'd0);
      check("ready_after_resp", {31'b0, req_ready_o}, 32'd1);
      check("no_dual_strobe", {31'b0, both_hi}, 32'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      req_addr_i = 32'h0; req_wdata_i = 32'h0; mem_data_i = 32'h0; mem_ack_i = 1'b0;
      #1;
      check("rst_ready", {31'b0, req_ready_o}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
      check("rst_rd", {31'b0, mem_read_o}, 32'd0);
      check("rst_wr", {31'b0, mem_write_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_rdata", resp_rdata_o, 32'h0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // byte loads on 0x80FF_7F01 at 0x10
      run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 32'h80FF_7F01);
      check("lb13_data", r_data, 32'hFFFF_FF80);
      check("lb13_lat", 32'(lat), 32'd2);
      check("lb13_err", {31'b0, r_err}, 32'd0);
      check("lb13_addr", {31'b0, addr_ok}, 32'd1);
      run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0, 32'h80FF_7F01);
      check("lbu12_data", r_data, 32'h0000_00FF);
      run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 32'h80FF_7F01);
      check("lb11_data", r_data, 32'h0000_007F);

      // half loads
      run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h80FF_7F01);
      check("lh12_data", r_data, 32'hFFFF_80FF);
      run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, 32'h80FF_7F01);
      check("lhu10_data", r_data, 32'h0000_7F01);
      run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 32'h80FF_7F01);
      check("lh11_err", {31'b0, r_err}, 32'd1);
      check("lh11_nrd", 32'(n_rd), 32'd0);
      check("lh11_data", r_data, 32'h0);
      check("lh11_lat", 32'(lat), 32'd1);
      check("err_hold", {31'b0, resp_err_o}, 32'd1);
      run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 32'h80FF_7F01);
      check("size11_err", {31'b0, r_err}, 32'd1);
      check("size11_nrd", 32'(n_rd), 32'd0);
      run_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, 32'h80FF_7F01);
      check("lw12_err", {31'b0, r_err}, 32'd1);

      // sub-word stores on 0x1122_3344 at 0x20
      run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AB, 0, 32'h1122_3344);
      check("sb21_merge", wdata_seen, 32'h1122_AB44);
      check("sb21_lat", 32'(lat), 32'd3);
      check("sb21_nrd", 32'(n_rd), 32'd1);
      check("sb21_nwr", 32'(n_wr), 32'd1);
      check("sb21_addr", {31'b0, addr_ok}, 32'd1);
      check("sb21_rdata", r_data, 32'h0);
      run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 0, 32'h1122_3344);
      check("sh22_merge", wdata_seen, 32'hBEEF_3344);
      check("sh22_lat", 32'(lat), 32'd3);

      // word store then load with 3-cycle ack delay
      run_req(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEAD_BEEF, 0, 32'h0);
      check("sw04_data", wdata_seen, 32'hDEAD_BEEF);
      check("sw04_lat", 32'(lat), 32'd2);
      check("sw04_nrd", 32'(n_rd), 32'd0);
      check("sw04_err", {31'b0, r_err}, 32'd0);
      run_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 3, wdata_seen);
      check("lw04_data", r_data, 32'hDEAD_BEEF);
      check("lw04_lat", 32'(lat), 32'd5);
      check("lw04_nrd", 32'(n_rd), 32'd4);
      check("lw04_addr", {31'b0, addr_ok}, 32'd1);

      // timeouts
      run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, -1, 32'h5555_5555);
      check("to_lw_nrd", 32'(n_rd), 32'd16);
      check("to_lw_err", {31'b0, r_err}, 32'd1);
      check("to_lw_data", r_data, 32'h0);
      check("to_lw_lat", 32'(lat), 32'd17);
      run_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0012, -1, 32'h5555_5555);
      check("to_rmw_nwr", 32'(n_wr), 32'd0);
      check("to_rmw_nrd", 32'(n_rd), 32'd16);
      check("to_rmw_err", {31'b0, r_err}, 32'd1);

      // async reset in the middle of a write
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
      req_addr_i = 32'h30; req_wdata_i = 32'hCAFE_F00D; mem_ack_i = 1'b0;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("rstwr_strobe", {31'b0, mem_write_o}, 32'd1);
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      check("rstwr_wr_drop", {31'b0, mem_write_o}, 32'd0);
      check("rstwr_rd_low", {31'b0, mem_read_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("rstwr_no_resp", {31'b0, resp_valid_o}, 32'd0);
         check("rstwr_ready", {31'b0, req_ready_o}, 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
